vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
// A clock divider produces a one-clk pixel enable; free-running horizontal and
// vertical counters advance on it and are exported directly as x/y. Sync,
// blanking and frame-start are decoded combinationally from the counters so
// they line up with x/y in the same cycle.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter
// output (frame_cnt) that increments on every frame_start strobe.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_b,
   output logic       sync_b,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic       frame_start,
   output logic [7:0] frame_cnt
`else
   output logic       frame_start
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Wrap points and decode boundaries, sized to the counter widths.
   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [3:0] div_q;
   logic [3:0] div_d;
   logic [9:0] hcnt_q;
   logic [9:0] hcnt_d;
   logic [9:0] vcnt_q;
   logic [9:0] vcnt_d;
   logic       tick_s;
   logic       line_end_s;

   // Pixel enable and end-of-line detect from the current counter state.
   always_comb begin
      tick_s     = (div_q == DIV_LAST);
      line_end_s = (hcnt_q == H_LAST);
   end

   // Next-state for the divider and the horizontal/vertical counters.
   always_comb begin
      div_d  = div_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (tick_s) begin
         div_d = 4'd0;
         if (line_end_s) begin
            hcnt_d = 10'd0;
            if (vcnt_q == V_LAST) begin
               vcnt_d = 10'd0;
            end else begin
               vcnt_d = vcnt_q + 10'd1;
            end
         end else begin
            hcnt_d = hcnt_q + 10'd1;
            vcnt_d = vcnt_q;
         end
      end else begin
         div_d  = div_q + 4'd1;
         hcnt_d = hcnt_q;
         vcnt_d = vcnt_q;
      end
   end

   // Counter state; reset returns the raster to pixel (0,0), divider phase 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= 4'd0;
         hcnt_q <= 10'd0;
         vcnt_q <= 10'd0;
      end else begin
         div_q  <= div_d;
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Output decode, combinational so every strobe is aligned with x/y.
   always_comb begin
      pix_tick    = tick_s;
      x           = hcnt_q;
      y           = vcnt_q;
      sync_b      = 1'b0;
      blank_b     = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      frame_start = tick_s && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
      if ((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST)) begin
         hsync = 1'b0;
      end else begin
         hsync = 1'b1;
      end
      if ((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST)) begin
         vsync = 1'b0;
      end else begin
         vsync = 1'b1;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] fcnt_q;
   logic [7:0] fcnt_d;

   // Frame counter advances once per frame_start and wraps naturally at 255.
   always_comb begin
      if (frame_start) begin
         fcnt_d = fcnt_q + 8'd1;
      end else begin
         fcnt_d = fcnt_q;
      end
   end

   // Frame counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= 8'd0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances: full 640x480 timing at
// CLK_DIV=2 (a), full timing at CLK_DIV=1 (b), and a miniature raster at
// CLK_DIV=2 (c: 8x7 total, 4x3 visible) so whole frames fit in a short run.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n = 1'b0;
   logic rst_b_n = 1'b0;
   logic rst_c_n = 1'b0;

   logic       a_tick, a_hs, a_vs, a_bl, a_sb, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_hs, b_vs, b_bl, b_sb, b_fs;
   logic [9:0] b_x, b_y;
   logic       c_tick, c_hs, c_vs, c_bl, c_sb, c_fs;
   logic [9:0] c_x, c_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] a_fc, b_fc, c_fc;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   vga_timing_gen dut_a (
      .clk(clk), .rst_n(rst_a_n), .pix_tick(a_tick), .x(a_x), .y(a_y),
      .hsync(a_hs), .vsync(a_vs), .blank_b(a_bl), .sync_b(a_sb),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(a_fc),
`endif
      .frame_start(a_fs)
   );

   vga_timing_gen #(.CLK_DIV(1)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .pix_tick(b_tick), .x(b_x), .y(b_y),
      .hsync(b_hs), .vsync(b_vs), .blank_b(b_bl), .sync_b(b_sb),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(b_fc),
`endif
      .frame_start(b_fs)
   );

   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_c (
      .clk(clk), .rst_n(rst_c_n), .pix_tick(c_tick), .x(c_x), .y(c_y),
      .hsync(c_hs), .vsync(c_vs), .blank_b(c_bl), .sync_b(c_sb),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(c_fc),
`endif
      .frame_start(c_fs)
   );

   task automatic test_reset();
      int guard;
      @(negedge clk);
      rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
      #1;
      n_chk++;
      if (a_x !== 10'd0 || a_y !== 10'd0 || a_hs !== 1'b1 || a_vs !== 1'b1 || a_bl !== 1'b1 ||
          a_tick !== 1'b0 || a_fs !== 1'b0 || a_sb !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: x=%0d y=%0d hs=%b vs=%b bl=%b tick=%b fs=%b sb=%b, want 0 0 1 1 1 0 0 0",
                  a_x, a_y, a_hs, a_vs, a_bl, a_tick, a_fs, a_sb);
      end
      n_chk++;
      if (b_tick !== 1'b1 || b_fs !== 1'b1 || b_x !== 10'd0 || b_sb !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b_div1: tick=%b fs=%b x=%0d sb=%b, want 1 1 0 0", b_tick, b_fs, b_x, b_sb);
      end
      // Release a: first tick after one clock, x=1 after two clocks.
      @(negedge clk);
      rst_a_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (a_x !== 10'd0 || a_tick !== 1'b1 || a_fs !== 1'b1) begin
         n_fail++;
         $display("FAIL release_clock1: x=%0d tick=%b fs=%b, want 0 1 1", a_x, a_tick, a_fs);
      end
      @(negedge clk);
      n_chk++;
      if (a_x !== 10'd1 || a_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL release_clock2: x=%0d tick=%b, want 1 0", a_x, a_tick);
      end
      // Mid-line reset at x=300.
      guard = 0;
      while (a_x !== 10'd300 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      n_chk++;
      if (a_x !== 10'd300) begin
         n_fail++;
         $display("FAIL reach_x300: x=%0d, want 300 within 2000 clocks", a_x);
      end
      #2 rst_a_n = 1'b0;
      #1;
      n_chk++;
      if (a_x !== 10'd0 || a_y !== 10'd0 || a_hs !== 1'b1 || a_vs !== 1'b1 || a_bl !== 1'b1 || a_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midline: x=%0d y=%0d hs=%b vs=%b bl=%b tick=%b, want 0 0 1 1 1 0",
                  a_x, a_y, a_hs, a_vs, a_bl, a_tick);
      end
      // Mid-frame reset on the mini raster inside both sync pulses.
      @(negedge clk);
      rst_c_n = 1'b1;
      guard = 0;
      while (!(c_y === 10'd4 && c_x === 10'd5) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      n_chk++;
      if (c_hs !== 1'b0 || c_vs !== 1'b0 || c_bl !== 1'b0) begin
         n_fail++;
         $display("FAIL mini_sync_at_5_4: hs=%b vs=%b bl=%b, want 0 0 0", c_hs, c_vs, c_bl);
      end
      #2 rst_c_n = 1'b0;
      #1;
      n_chk++;
      if (c_x !== 10'd0 || c_y !== 10'd0 || c_hs !== 1'b1 || c_vs !== 1'b1 || c_bl !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midframe: x=%0d y=%0d hs=%b vs=%b bl=%b, want 0 0 1 1 1",
                  c_x, c_y, c_hs, c_vs, c_bl);
      end
   endtask

   task automatic test_horizontal();
      int p, ex, ey, hs_low, errs;
      logic etick, ehs, ebl, efs;
      hs_low = 0; errs = 0;
      @(negedge clk);
      rst_a_n = 1'b1;
      #1;
      for (int k = 0; k < 3206; k++) begin
         p = k / 2; ex = p % 800; ey = p / 800;
         etick = (k % 2 == 1);
         ehs = !(ex >= 656 && ex <= 751);
         ebl = (ex < 640) && (ey < 480);
         efs = etick && ex == 0 && ey == 0;
         n_chk++;
         if (a_x !== 10'(ex) || a_y !== 10'(ey) || a_tick !== etick || a_hs !== ehs ||
             a_vs !== 1'b1 || a_bl !== ebl || a_fs !== efs) begin
            n_fail++; errs++;
            $display("FAIL horiz_clk%0d: x=%0d y=%0d tick=%b hs=%b vs=%b bl=%b fs=%b, want %0d %0d %b %b 1 %b %b",
                     k, a_x, a_y, a_tick, a_hs, a_vs, a_bl, a_fs, ex, ey, etick, ehs, ebl, efs);
         end
         if (k < 1600 && a_hs === 1'b0) hs_low++;
         if (k == 1599) begin
            n_chk++;
            if (a_x !== 10'd799 || a_y !== 10'd0) begin
               n_fail++;
               $display("FAIL line_end: x=%0d y=%0d, want 799 0", a_x, a_y);
            end
         end
         if (k == 1600) begin
            n_chk++;
            if (a_x !== 10'd0 || a_y !== 10'd1) begin
               n_fail++;
               $display("FAIL line_wrap: x=%0d y=%0d, want 0 1", a_x, a_y);
            end
         end
         if (errs > 8) break;
         @(negedge clk);
      end
      n_chk++;
      if (hs_low != 192) begin
         n_fail++;
         $display("FAIL hsync_width_div2: %0d clocks low, want 192", hs_low);
      end
   endtask

   task automatic test_clkdiv1();
      int ex, ey, hs_low, errs;
      logic ehs, ebl, efs;
      hs_low = 0; errs = 0;
      @(negedge clk);
      rst_b_n = 1'b1;
      #1;
      for (int k = 0; k < 1606; k++) begin
         ex = k % 800; ey = k / 800;
         ehs = !(ex >= 656 && ex <= 751);
         ebl = (ex < 640) && (ey < 480);
         efs = (ex == 0) && (ey == 0);
         n_chk++;
         if (b_x !== 10'(ex) || b_y !== 10'(ey) || b_tick !== 1'b1 || b_hs !== ehs ||
             b_bl !== ebl || b_fs !== efs) begin
            n_fail++; errs++;
            $display("FAIL div1_clk%0d: x=%0d y=%0d tick=%b hs=%b bl=%b fs=%b, want %0d %0d 1 %b %b %b",
                     k, b_x, b_y, b_tick, b_hs, b_bl, b_fs, ex, ey, ehs, ebl, efs);
         end
         if (k < 800 && b_hs === 1'b0) hs_low++;
         if (errs > 8) break;
         @(negedge clk);
      end
      n_chk++;
      if (hs_low != 96) begin
         n_fail++;
         $display("FAIL hsync_width_div1: %0d clocks low, want 96", hs_low);
      end
   endtask

   task automatic test_vertical();
      int p, ex, ey, vs_low, bl_low, errs;
      logic etick, ehs, evs, ebl, efs;
      vs_low = 0; bl_low = 0; errs = 0;
      @(negedge clk);
      rst_c_n = 1'b1;
      #1;
      for (int k = 0; k < 229; k++) begin
         p = k / 2; ex = p % 8; ey = (p / 8) % 7;
         etick = (k % 2 == 1);
         ehs = !(ex >= 5 && ex <= 6);
         evs = !(ey >= 4 && ey <= 5);
         ebl = (ex < 4) && (ey < 3);
         efs = etick && ex == 0 && ey == 0;
         n_chk++;
         if (c_x !== 10'(ex) || c_y !== 10'(ey) || c_tick !== etick || c_hs !== ehs ||
             c_vs !== evs || c_bl !== ebl || c_fs !== efs) begin
            n_fail++; errs++;
            $display("FAIL vert_clk%0d: x=%0d y=%0d tick=%b hs=%b vs=%b bl=%b fs=%b, want %0d %0d %b %b %b %b %b",
                     k, c_x, c_y, c_tick, c_hs, c_vs, c_bl, c_fs, ex, ey, etick, ehs, evs, ebl, efs);
         end
         if (k < 112 && c_vs === 1'b0) vs_low++;
         if (k < 112 && ey >= 3 && c_bl === 1'b0) bl_low++;
         if (errs > 8) break;
         @(negedge clk);
      end
      n_chk++;
      if (vs_low != 32) begin
         n_fail++;
         $display("FAIL vsync_width: %0d clocks low, want 32", vs_low);
      end
      n_chk++;
      if (bl_low != 64) begin
         n_fail++;
         $display("FAIL vblank_rows: %0d blanked clocks in rows 3..6, want 64", bl_low);
      end
   endtask

   task automatic test_frame_length();
      int guard, gap;
      guard = 0;
      while (c_fs !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      for (int f = 0; f < 3; f++) begin
         n_chk++;
         if (c_fs !== 1'b1 || c_x !== 10'd0 || c_y !== 10'd0 || c_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_pos%0d: fs=%b x=%0d y=%0d tick=%b, want 1 0 0 1",
                     f, c_fs, c_x, c_y, c_tick);
         end
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (c_fs !== 1'b1 && gap < 300);
         n_chk++;
         if (gap != 112) begin
            n_fail++;
            $display("FAIL frame_period%0d: %0d clocks, want 112", f, gap);
         end
      end
   endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
   task automatic test_frame_cnt();
      logic [7:0] fc_exp;
      logic [7:0] prev;
      int stage, errs;
      stage = 0; errs = 0; fc_exp = 8'd0; prev = 8'd0;
      @(negedge clk);
      rst_c_n = 1'b0;
      #1;
      n_chk++;
      if (c_fc !== 8'd0) begin
         n_fail++;
         $display("FAIL fcnt_reset: frame_cnt=%0d, want 0", c_fc);
      end
      @(negedge clk);
      rst_c_n = 1'b1;
      for (int k = 0; k < 257 * 112 + 20; k++) begin
         n_chk++;
         if (c_fc !== fc_exp) begin
            n_fail++; errs++;
            $display("FAIL fcnt_clk%0d: frame_cnt=%0d, want %0d", k, c_fc, fc_exp);
         end
         if (stage == 0 && c_fc === 8'd0 && prev === 8'd255) stage = 1;
         if (stage == 1 && c_fc === 8'd1 && prev === 8'd0) stage = 2;
         prev = c_fc;
         if (c_fs === 1'b1) fc_exp = fc_exp + 8'd1;
         if (errs > 8) break;
         @(negedge clk);
      end
      n_chk++;
      if (stage != 2) begin
         n_fail++;
         $display("FAIL fcnt_wrap: sequence 255,0,1 reached stage %0d, want 2", stage);
      end
      #2 rst_c_n = 1'b0;
      #1;
      n_chk++;
      if (c_fc !== 8'd0) begin
         n_fail++;
         $display("FAIL fcnt_midreset: frame_cnt=%0d, want 0", c_fc);
      end
      @(negedge clk);
      rst_c_n = 1'b1;
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_horizontal();
      test_clkdiv1();
      test_vertical();
      test_frame_length();
`ifdef VGA_TIMING_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
